// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with BRAM issue, PC-tagged FIFO and redirect flush
//
// Purpose:
//   Issues sequential word addresses to a 1-cycle-latency instruction BRAM.
//   Captures each returned word together with its PC into a DEPTH-entry FIFO.
//   Presents the head entry to decode over a valid/ready handshake.
//   A redirect pulse flushes the FIFO and any in-flight read, then restarts
//   fetch at redirect_pc.
//
// Optional feature:
//   FETCH_QUEUE_BYPASS_EN - when defined, a word returning into an empty
//   queue is presented combinationally in the same cycle. If the consumer
//   takes it, the word is never written into the FIFO.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   en           fetch enable; no new reads are issued while low
//   redirect     one-cycle flush/restart pulse
//   redirect_pc  restart PC, sampled with redirect
//   mem_addr     BRAM read address (always the current fetch PC)
//   mem_rdata    BRAM read data, one cycle after mem_addr
//   instr        head-of-queue instruction
//   instr_pc     PC of instr
//   instr_valid  head entry valid
//   instr_ready  consumer accepts the head this cycle
//   count        occupied FIFO entries (0..DEPTH)

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_STEP  = 32'd1,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic [31:0]                mem_addr,
    input  logic [31:0]                mem_rdata,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   issued_pc_q, issued_pc_d;
    logic          inflight_q, inflight_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pcs_q  [DEPTH];

    logic          fetching;
    logic          space_ok;
    logic          issue;
    logic          head_valid;
    logic          push;
    logic          pop;
    logic          byp_take;
    logic [OW-1:0] occupancy;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en)  state_d = S_FETCH;
            S_FETCH: if (!en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Issue follows the state being entered, so the first read goes out in
    // the same cycle en is first seen high and drops the cycle en falls.
    assign fetching = (state_d == S_FETCH);

    // An issued read always has a slot reserved: count plus the read already
    // in flight must leave room for it.
    assign occupancy  = OW'(count_q) + OW'(inflight_q);
    assign space_ok   = occupancy < DEPTH_OCC;
    assign issue      = fetching && !redirect && space_ok;
    assign head_valid = (count_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass      = (count_q == '0) && inflight_q && !redirect;
    assign instr_valid = head_valid || bypass;
    assign instr       = bypass ? mem_rdata   : data_q[rd_ptr_q];
    assign instr_pc    = bypass ? issued_pc_q : pcs_q[rd_ptr_q];
    assign byp_take    = bypass && instr_ready;
`else
    assign instr_valid = head_valid;
    assign instr       = data_q[rd_ptr_q];
    assign instr_pc    = pcs_q[rd_ptr_q];
    assign byp_take    = 1'b0;
`endif

    assign push = inflight_q && !redirect && !byp_take;
    assign pop  = head_valid && instr_ready && !redirect;

    always_comb begin
        fpc_d       = fpc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (redirect) begin
            fpc_d    = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                inflight_d  = 1'b1;
                issued_pc_d = fpc_q;
                fpc_d       = fpc_q + PC_STEP;
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fpc_q       <= RESET_PC;
            issued_pc_q <= RESET_PC;
            inflight_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            // Cleared so the head outputs read zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            if (push) begin
                data_q[wr_ptr_q] <= mem_rdata;
                pcs_q[wr_ptr_q]  <= issued_pc_q;
            end
        end
    end

    assign mem_addr = fpc_q;
    assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue

module tb_fetch_queue;

    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(.DEPTH(DEPTH), .PC_STEP(32'd1), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst), .en(en), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .count(count)
    );

    always #5 clk = ~clk;

    // BRAM: word at address a is 0x1000 + a, one cycle read latency.
    always @(posedge clk) mem_rdata <= mem_addr + 32'h1000;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        en = 1'b1; instr_ready = 1'b0;
        repeat (4) tick;
        rst = 1'b1; en = 1'b1; redirect = 1'b1; redirect_pc = 32'h55; instr_ready = 1'b1;
        tick;
        rst = 1'b0; en = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h exp 0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp 0", instr_pc); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    endtask

    task automatic test_stream;
        do_reset;
        en = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            n_cmp++;
            if (instr_valid !== (k >= LAT)) begin
                n_err++; $display("FAIL stream_valid cyc %0d got %b exp %b", k, instr_valid, (k >= LAT));
            end
            if (k >= LAT) begin
                n_cmp++;
                if (instr_pc !== 32'(k - LAT) || instr !== 32'(k - LAT) + 32'h1000) begin
                    n_err++; $display("FAIL stream_data cyc %0d got %h/%h exp %h/%h",
                                      k, instr, instr_pc, 32'(k - LAT) + 32'h1000, 32'(k - LAT));
                end
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        int got;
        do_reset;
        en = 1'b1; instr_ready = 1'b0;
        repeat (10) tick;
        #1;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL bp_count got %0d exp 4", count); end
        n_cmp++; if (mem_addr !== 32'd4) begin n_err++; $display("FAIL bp_addr got %h exp 4", mem_addr); end
        instr_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            #1;
            if (instr_valid) begin
                n_cmp++;
                if (instr_pc !== 32'(got) || instr !== 32'(got) + 32'h1000) begin
                    n_err++; $display("FAIL bp_order got %h/%h exp %h/%h", instr, instr_pc, 32'(got) + 32'h1000, 32'(got));
                end
                got++;
            end
            tick;
        end
        n_cmp++; if (got != 8) begin n_err++; $display("FAIL bp_timeout got %0d exp 8", got); end
    endtask

    task automatic test_redirect(input bit with_ready);
        int got;
        bit seen;
        do_reset;
        en = 1'b1; instr_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (count == 3'd3) seen = 1'b1;
            else tick;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL redir_setup got count %0d exp 3", count); end
        redirect = 1'b1; redirect_pc = 32'h40; instr_ready = with_ready;
        tick;
        redirect = 1'b0; instr_ready = 1'b1;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid rdy=%0d got %b exp 0", with_ready, instr_valid); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL redir_count rdy=%0d got %0d exp 0", with_ready, count); end
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            #1;
            if (instr_valid) begin
                n_cmp++;
                if (instr_pc !== 32'h40 + 32'(got) || instr !== 32'h1040 + 32'(got)) begin
                    n_err++; $display("FAIL redir_seq rdy=%0d got %h/%h exp %h/%h", with_ready, instr, instr_pc,
                                      32'h1040 + 32'(got), 32'h40 + 32'(got));
                end
                got++;
            end
            tick;
        end
        n_cmp++; if (got != 4) begin n_err++; $display("FAIL redir_timeout got %0d exp 4", got); end
    endtask

    task automatic test_rst_mid;
        bit seen;
        bit done;
        do_reset;
        en = 1'b1; instr_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (count == 3'd2) seen = 1'b1;
            else tick;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL rstmid_setup got count %0d exp 2", count); end
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h77; instr_ready = 1'b1;
        tick;
        rst = 1'b0; redirect = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b exp 0", instr_valid); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rstmid_count got %0d exp 0", count); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_addr got %h exp 0", mem_addr); end
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            #1;
            if (instr_valid) begin
                done = 1'b1;
                n_cmp++;
                if (instr_pc !== 32'h0) begin n_err++; $display("FAIL rstmid_first got %h exp 0", instr_pc); end
            end
            tick;
        end
        n_cmp++; if (!done) begin n_err++; $display("FAIL rstmid_timeout got none exp valid"); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc [3];
        int got;
        exp_pc[0] = 32'hFFFF_FFFF; exp_pc[1] = 32'h0; exp_pc[2] = 32'h1;
        do_reset;
        en = 1'b1; instr_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick;
        redirect = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            #1;
            if (instr_valid) begin
                n_cmp++;
                if (instr_pc !== exp_pc[got] || instr !== exp_pc[got] + 32'h1000) begin
                    n_err++; $display("FAIL wrap_seq got %h/%h exp %h/%h", instr, instr_pc, exp_pc[got] + 32'h1000, exp_pc[got]);
                end
                got++;
            end
            tick;
        end
        n_cmp++; if (got != 3) begin n_err++; $display("FAIL wrap_timeout got %0d exp 3", got); end
    endtask

    // Transaction-level reference: a queue of buffered PCs plus one optional
    // outstanding read; data for a PC is always 0x1000 + PC.
    task automatic test_random;
        logic [31:0] mq[$];
        logic [31:0] m_fpc, m_ipc, e_pc;
        bit          m_inf, e_byp, e_valid, take_byp, do_issue;
        int          occ;
        do_reset;
        mq = {}; m_fpc = 32'h0; m_ipc = 32'h0; m_inf = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            en          = ($urandom_range(0, 9) != 0);
            instr_ready = ($urandom_range(0, 9) < 6);
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            #1;
            e_byp   = BYP && (mq.size() == 0) && m_inf && !redirect;
            e_valid = (mq.size() != 0) || e_byp;
            e_pc    = e_byp ? m_ipc : ((mq.size() != 0) ? mq[0] : 32'h0);
            n_cmp++;
            if (count !== 3'(mq.size()) || mem_addr !== m_fpc || instr_valid !== e_valid) begin
                n_err++; $display("FAIL rand_state cyc %0d got cnt=%0d addr=%h v=%b exp cnt=%0d addr=%h v=%b",
                                  c, count, mem_addr, instr_valid, mq.size(), m_fpc, e_valid);
            end
            if (e_valid) begin
                n_cmp++;
                if (instr_pc !== e_pc || instr !== e_pc + 32'h1000) begin
                    n_err++; $display("FAIL rand_head cyc %0d got %h/%h exp %h/%h", c, instr, instr_pc, e_pc + 32'h1000, e_pc);
                end
            end
            if (redirect) begin
                mq = {}; m_inf = 1'b0; m_fpc = redirect_pc;
            end else begin
                occ      = mq.size() + int'(m_inf);
                do_issue = en && (occ < DEPTH);
                take_byp = e_byp && instr_ready;
                if (instr_ready && mq.size() != 0) void'(mq.pop_front());
                if (m_inf && !take_byp) mq.push_back(m_ipc);
                if (do_issue) begin
                    m_inf = 1'b1; m_ipc = m_fpc; m_fpc = m_fpc + 32'h1;
                end else begin
                    m_inf = 1'b0;
                end
            end
            tick;
        end
        redirect = 1'b0;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect(1'b0);
        test_redirect(1'b1);
        test_rst_mid;
        test_wrap;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Issues sequential read addresses to the instruction BRAM, which has 1-cycle read latency.
- Buffers the returned words with their PCs in a small FIFO.
- Presents them to the decode/control stage over a valid/ready handshake.
- On a taken branch or jump, a redirect flushes the FIFO and any in-flight read, then restarts fetch at the new PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PC_STEP, 1, increment added to the fetch PC per issued read (word addressing).
- RESET_PC, 0, fetch PC value after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  fetch enable; no new reads are issued while low
- redirect  input  1  one-cycle pulse: flush and restart fetch at redirect_pc
- redirect_pc  input  32  new fetch PC, sampled when redirect=1
- mem_addr  output  32  instruction BRAM read address
- mem_rdata  input  32  BRAM read data, valid 1 cycle after the address
- instr  output  32  head-of-queue instruction
- instr_pc  output  32  PC of instr
- instr_valid  output  1  head entry is valid
- instr_ready  input  1  consumer accepts head this cycle
- count  output  $clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (rst=1 at clock edge):
  - fpc=RESET_PC; rd_ptr=wr_ptr=count=0; inflight=0; state=IDLE.
  - Outputs after reset: instr_valid=0, instr=0, instr_pc=0, mem_addr=RESET_PC.
  - rst overrides redirect, en and instr_ready in the same cycle.
  - Reset mid-operation discards all entries and any in-flight read.
- State machine (2 states):
  - IDLE -> FETCH when en=1.
  - FETCH -> IDLE when en=0.
  - A redirect does not change state.
- Issue:
  - In FETCH, when (count + inflight) < DEPTH and redirect=0: drive mem_addr=fpc, set inflight<=1, issued_pc<=fpc, fpc<=fpc+PC_STEP.
  - No issue otherwise; inflight<=0 if nothing is issued.
  - mem_addr always equals the current fpc.
- Capture: when inflight=1 and no redirect, mem_rdata and issued_pc are written at wr_ptr the next cycle.
  - The space check at issue time guarantees a capture never overflows.
- Pop:
  - instr_valid = (count != 0); instr/instr_pc are registered head contents.
  - On instr_valid && instr_ready, rd_ptr advances.
  - Pop and capture in the same cycle leaves count unchanged.
- Pointers wrap modulo DEPTH. count is 0..DEPTH. Full when count=DEPTH.
- Pop while empty is ignored; count never underflows.
- Redirect (takes priority over issue, capture and pop in that cycle):
  - count<=0, pointers<=0, inflight<=0; returning data is dropped.
  - fpc<=redirect_pc.
  - First issue at redirect_pc occurs in the following cycle if in FETCH.
  - instr_valid=0 in the cycle after the redirect.
- The en=0 -> 1 transition resumes at the retained fpc. An in-flight read issued before en fell is still captured.
- Latency, no bypass: issue at cycle N -> captured at the N+1 edge -> instr_valid=1 in cycle N+2.
- Steady-state throughput: 1 instruction per cycle while instr_ready=1 and count+inflight < DEPTH.
- PC arithmetic is 32-bit unsigned and wraps 0xFFFFFFFF+1 -> 0.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count=0, inflight=1 and no redirect, mem_rdata/issued_pc drive instr/instr_pc combinationally with instr_valid=1 in cycle N+1.
  - If instr_ready=1 that cycle, the word is consumed and not written to the FIFO.
  - If instr_ready=0, the word is written normally.
- Not defined: all data passes through the FIFO, giving the 2-cycle latency above.
- Functional sequence (order of instructions and PCs) must be identical either way.

Test Plan:
- Reset then en=1, instr_ready=1, BRAM holds word k = 0x1000+k → instr_valid first high in cycle 2 (cycle 1 with bypass); instr/instr_pc sequence 0x1000/0, 0x1001/1, 0x1002/2… at one per cycle.
- en=1, instr_ready=0 for 10 cycles → count saturates at 4; mem_addr stops advancing at 4; then instr_ready=1 → PCs 0..4+ delivered in order, none lost or duplicated.
- Steady stream, pulse redirect with redirect_pc=0x40 while inflight=1 and count=3 → next cycle instr_valid=0, count=0; next valid instruction has instr_pc=0x40; the in-flight word never appears.
- redirect and instr_ready high in the same cycle as a capture → redirect wins; count=0; only the 0x40 stream follows.
- rst asserted mid-stream with count=2 → next cycle instr_valid=0, count=0, mem_addr=RESET_PC; fetch restarts at PC 0.
- redirect_pc=0xFFFFFFFF, PC_STEP=1 → instr_pc sequence 0xFFFFFFFF, 0x00000000, 0x00000001.
